// File: rtl/xip_spi_reader_pkg.sv
// Purpose : shared constants, FSM state type and byte-order helper for the
//           execute-in-place SPI flash read engine.
// Contents: XIP_CMD_READ   - SPI READ opcode sent ahead of the address
//           XIP_FRAME_BITS - command + address + data bits per frame
//           xip_state_t    - engine FSM states
//           xip_byte_swap  - reorders a received stream into a little-endian word
package xip_pkg;

    localparam logic [7:0] XIP_CMD_READ   = 8'h03;
    localparam int         XIP_FRAME_BITS = 64;
    localparam int         XIP_BIT_CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2,
        ST_GAP   = 2'd3
    } xip_state_t;

    // The flash streams byte 0 first, so byte 0 ends up in the top byte of the
    // receive register; the response word wants byte k at bits [8k+7:8k].
    function automatic logic [31:0] xip_byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/xip_spi_reader_if.sv
// Purpose : request/response bus between the instruction-fetch side and the
//           XIP flash read engine.
// Signals : req_valid/req_ready/req_addr - one 24-bit word-read request
//           rsp_valid/rsp_data           - one-cycle response pulse + held data
// Modports: master = fetch side, slave = read engine.
interface xip_spi_reader_if;

    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/xip_spi_reader_sclk_div.sv
// Purpose : SPI half-period timer. Counts CLK_DIV system cycles per phase and
//           flags the last cycle of each phase, alternating low/high phases.
// Ports   : clk, arstn         - system clock, async active-low reset
//           i_en               - count enable (engine shifting or in the gap)
//           i_clr              - restart at the beginning of a low phase
//           o_phase_end        - this cycle is the last of the current phase
//           o_phase_is_high    - current phase is the SPI-clock-high phase
module xip_sclk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_phase_end,
    output logic o_phase_is_high
);

    localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_high;
    logic       w_last;

    assign w_last          = (r_cnt == CNT_MAX);
    assign o_phase_end     = i_en && w_last;
    assign o_phase_is_high = r_high;

    // Half-period counter; toggles the phase each time a phase completes.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_cnt  <= 8'd0;
            r_high <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= 8'd0;
            r_high <= 1'b0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt  <= 8'd0;
                r_high <= ~r_high;
            end else begin
                r_cnt  <= r_cnt + 8'd1;
                r_high <= r_high;
            end
        end else begin
            r_cnt  <= r_cnt;
            r_high <= r_high;
        end
    end

endmodule

// File: rtl/xip_spi_reader.sv
// Purpose : execute-in-place SPI flash read engine. Turns a single 32-bit word
//           read request into an SPI mode-0 READ (0x03) frame: 8 command bits,
//           24 address bits, then 32 data bits captured from the flash and
//           returned as a little-endian word. One transaction at a time.
// Params  : CLK_DIV - SPI half-period in clk cycles (1..255)
// Ports   : clk, arstn        - system clock, async active-low reset
//           bus (slave)       - req_valid/req_ready/req_addr, rsp_valid/rsp_data
//           xip_csn           - flash chip select, active-low
//           xip_clk           - SPI clock, idles low
//           xip_sdo / xip_sdi - controller-to-flash / flash-to-controller data
module xip_spi_reader
    import xip_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                    clk,
    input  logic                    arstn,
    xip_spi_reader_if.slave         bus,
    output logic                    xip_csn,
    output logic                    xip_clk,
    output logic                    xip_sdo,
    input  logic                    xip_sdi
);

    xip_state_t                 r_state;
    logic [31:0]                r_tx;
    logic [31:0]                r_rx;
    logic [31:0]                r_rsp_data;
    logic [XIP_BIT_CNT_W-1:0]   r_bit_cnt;
    logic                       r_csn;
    logic                       r_sclk;
    logic                       r_sdo;
    logic                       r_rsp_valid;
    logic                       r_req_ready;

    logic                       w_accept;
    logic                       w_div_en;
    logic                       w_phase_end;
    logic                       w_phase_high;
    logic [31:0]                w_tx_load;

    assign w_tx_load = {XIP_CMD_READ, bus.req_addr};
    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    assign w_div_en  = (r_state == ST_SHIFT) || (r_state == ST_GAP);

    xip_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk             (clk),
        .arstn           (arstn),
        .i_en            (w_div_en),
        .i_clr           (w_accept),
        .o_phase_end     (w_phase_end),
        .o_phase_is_high (w_phase_high)
    );

    // Engine FSM; every pad and bus output is a flop updated here.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= ST_IDLE;
            r_tx        <= 32'd0;
            r_rx        <= 32'd0;
            r_rsp_data  <= 32'd0;
            r_bit_cnt   <= '0;
            r_csn       <= 1'b1;
            r_sclk      <= 1'b0;
            r_sdo       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        r_state     <= ST_SHIFT;
                        r_tx        <= w_tx_load;
                        r_bit_cnt   <= '0;
                        r_csn       <= 1'b0;
                        r_sclk      <= 1'b0;
                        r_sdo       <= w_tx_load[31];
                        r_req_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        if (!w_phase_high) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: capture the flash bit and present
                            // the next outgoing bit (zeros once the address is out).
                            r_sclk    <= 1'b0;
                            r_rx      <= {r_rx[30:0], xip_sdi};
                            r_tx      <= {r_tx[30:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                            if (r_bit_cnt == 6'(XIP_FRAME_BITS - 1)) begin
                                r_state <= ST_RESP;
                                r_csn   <= 1'b1;
                                r_sdo   <= 1'b0;
                            end else begin
                                r_sdo   <= r_tx[30];
                            end
                        end
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= xip_byte_swap(r_rx);
                    r_state     <= ST_GAP;
                end
                ST_GAP: begin
                    // Chip select stays high for one low + one high divider phase.
                    r_rsp_valid <= 1'b0;
                    if (w_phase_end && w_phase_high) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_csn       <= 1'b1;
                    r_sclk      <= 1'b0;
                    r_sdo       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign xip_csn       = r_csn;
    assign xip_clk       = r_sclk;
    assign xip_sdo       = r_sdo;

endmodule

// File: tb/tb_xip_spi_reader.sv
// Self-checking bench for xip_spi_reader. Two engines share clk/arstn:
// unit 0 with CLK_DIV=2 and unit 1 with CLK_DIV=1, each talking to its own
// behavioural flash. A cycle-level timing model derived from the frame timing
// rules predicts every output on every cycle; literal expectations pin the
// response words, serialized command/address words and pulse counts.
module tb_xip_spi_reader;

    logic        clk   = 1'b0;
    logic        arstn = 1'b0;
    int          cyc   = 0;

    logic        rq_valid [2];
    logic [23:0] rq_addr  [2];

    logic        o_csn  [2];
    logic        o_sclk [2];
    logic        o_sdo  [2];
    logic        o_rdy  [2];
    logic        o_rv   [2];
    logic [31:0] o_rd   [2];
    logic [31:0] cap_a  [2];
    logic [6:0]  rise_a [2];

    int          n_pass = 0;
    int          n_tot  = 0;

    int          pin_cyc  [2] = '{-1, -1};
    logic [31:0] pin_word [2];
    logic [31:0] pin_cap  [2];
    bit          fin      = 1'b0;
    bit          fin_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash memory contents: one hand-picked word, otherwise an address pattern.
    function automatic logic [31:0] flash_word(input logic [23:0] a);
        if (a == 24'h000100) return 32'hDEADBEEF;
        else                 return {a[7:0], a[15:8], a[23:16], 8'h5A};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int D = (g == 0) ? 2 : 1;

        xip_spi_reader_if u_if ();
        logic        csn_w, sclk_w, sdo_w, sdi_w;
        logic [6:0]  f_rise = 7'd0;
        logic [31:0] f_cap  = 32'd0;
        logic [31:0] f_word, f_stream;

        assign u_if.req_valid = rq_valid[g];
        assign u_if.req_addr  = rq_addr[g];

        xip_spi_reader #(.CLK_DIV(D)) u_dut (
            .clk     (clk),
            .arstn   (arstn),
            .bus     (u_if.slave),
            .xip_csn (csn_w),
            .xip_clk (sclk_w),
            .xip_sdo (sdo_w),
            .xip_sdi (sdi_w)
        );

        assign o_csn[g]  = csn_w;
        assign o_sclk[g] = sclk_w;
        assign o_sdo[g]  = sdo_w;
        assign o_rdy[g]  = u_if.req_ready;
        assign o_rv[g]   = u_if.rsp_valid;
        assign o_rd[g]   = u_if.rsp_data;
        assign cap_a[g]  = f_cap;
        assign rise_a[g] = f_rise;

        // Flash: count SPI rises per select, shift in the first 32 sdo bits.
        always @(posedge sclk_w or negedge csn_w) begin
            if (sclk_w) begin
                if (f_rise < 7'd32) f_cap <= {f_cap[30:0], sdo_w};
                f_rise <= f_rise + 7'd1;
            end else begin
                f_rise <= 7'd0;
                f_cap  <= 32'd0;
            end
        end

        // Flash reply: byte 0 first, MSB first; noise during command/address.
        always_comb begin
            f_word   = flash_word(f_cap[23:0]);
            f_stream = {f_word[7:0], f_word[15:8], f_word[23:16], f_word[31:24]};
            sdi_w    = f_rise[0];
            if (f_cap[31:24] == 8'h03 && f_rise >= 7'd33 && f_rise <= 7'd64)
                sdi_w = f_stream[7'd64 - f_rise];
        end
    end

    task automatic chk32(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s u%0d cyc=%0d actual=%h required=%h", nm, u, cyc, act, exp);
    endtask

    task automatic chk1(input string nm, input int u, input logic act, input logic exp);
        chk32(nm, u, {31'd0, act}, {31'd0, exp});
    endtask

    // Timing model + comparison, evaluated mid-cycle on every cycle.
    bit          m_act   [2];
    int          m_t0    [2];
    logic [23:0] m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_pulse [2];
    int          a_pulse [2];

    initial begin
        int d, dv;
        logic e_csn, e_sclk, e_sdo, e_rv, e_rdy;
        logic [31:0] frame;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                dv = (u == 0) ? 2 : 1;
                e_csn = 1'b1; e_sclk = 1'b0; e_sdo = 1'b0; e_rv = 1'b0; e_rdy = 1'b1;
                if (!arstn) begin
                    m_act[u]  = 1'b0;
                    m_data[u] = 32'd0;
                end else if (m_act[u]) begin
                    d     = cyc - m_t0[u];
                    frame = {8'h03, m_addr[u]};
                    if (d < 128 * dv) begin
                        e_csn  = 1'b0;
                        e_sclk = ((d / dv) % 2) == 1;
                        if (d / (2 * dv) < 32) e_sdo = frame[31 - d / (2 * dv)];
                    end
                    if (d == 128 * dv + 1) begin
                        e_rv      = 1'b1;
                        m_data[u] = flash_word(m_addr[u]);
                        m_pulse[u]++;
                    end
                    e_rdy = (d >= 130 * dv + 1);
                    if (e_rdy) m_act[u] = 1'b0;
                end
                if (o_rv[u] === 1'b1) a_pulse[u]++;
                chk1 ("xip_csn",   u, o_csn[u],  e_csn);
                chk1 ("xip_clk",   u, o_sclk[u], e_sclk);
                chk1 ("xip_sdo",   u, o_sdo[u],  e_sdo);
                chk1 ("rsp_valid", u, o_rv[u],   e_rv);
                chk1 ("req_ready", u, o_rdy[u],  e_rdy);
                chk32("rsp_data",  u, o_rd[u],   m_data[u]);
                if (cyc == pin_cyc[u]) begin
                    chk1 ("pin_rsp_valid", u, o_rv[u], 1'b1);
                    chk32("pin_rsp_data",  u, o_rd[u], pin_word[u]);
                    chk32("pin_cmd_addr",  u, cap_a[u], pin_cap[u]);
                    chk32("pin_rises",     u, {25'd0, rise_a[u]}, 32'd64);
                end
                if (arstn && e_rdy && rq_valid[u]) begin
                    m_act[u]  = 1'b1;
                    m_t0[u]   = cyc + 1;
                    m_addr[u] = rq_addr[u];
                end
            end
            if (fin && !fin_done) begin
                fin_done = 1'b1;
                chk32("pulses_model", 0, 32'(a_pulse[0]), 32'(m_pulse[0]));
                chk32("pulses_model", 1, 32'(a_pulse[1]), 32'(m_pulse[1]));
                chk32("pulses_total", 0, 32'(a_pulse[0]), 32'd5);
                chk32("pulses_total", 1, 32'(a_pulse[1]), 32'd2);
            end
        end
    end

    // One read on unit u starting at the next edge; optional address scramble.
    task automatic do_read(input int u, input logic [23:0] a, input logic [31:0] pw, input bit toggle);
        int dv;
        int acc;
        dv          = (u == 0) ? 2 : 1;
        rq_valid[u] = 1'b1;
        rq_addr[u]  = a;
        acc         = cyc + 1;
        pin_cyc[u]  = acc + 128 * dv + 1;
        pin_word[u] = pw;
        pin_cap[u]  = {8'h03, a};
        @(posedge clk); #1;
        rq_valid[u] = 1'b0;
        if (toggle) rq_addr[u] = 24'hFFFFFF;
        repeat (130 * dv + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
        rq_addr[0]  = 24'd0; rq_addr[1] = 24'd0;
        arstn = 1'b0;
        repeat (5) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk); #1;

        // Single read, CLK_DIV=2.
        do_read(0, 24'h000100, 32'hDEADBEEF, 1'b0);

        // Back-to-back with req_valid held: 0x000000 then 0x000004.
        rq_valid[0] = 1'b1;
        rq_addr[0]  = 24'h000000;
        @(posedge clk); #1;
        rq_addr[0]  = 24'h000004;
        repeat (262) @(posedge clk);
        #1 rq_valid[0] = 1'b0;
        repeat (262) @(posedge clk);
        #1;

        // CLK_DIV=1 reads.
        do_read(1, 24'h000100, 32'hDEADBEEF, 1'b0);
        do_read(1, 24'hABCDEF, 32'hEFCDAB5A, 1'b0);

        // Reset during address bit 20, then a fresh full frame.
        rq_valid[0] = 1'b1;
        rq_addr[0]  = 24'h000200;
        @(posedge clk); #1;
        rq_valid[0] = 1'b0;
        repeat (81) @(posedge clk);
        #1 arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk); #1;
        do_read(0, 24'h000200, 32'h0002005A, 1'b0);

        // Address changes after accept must not reach the frame.
        do_read(0, 24'h123456, 32'h5634125A, 1'b1);

        fin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/xip_spi_reader.md
# xip_spi_reader

Execute-in-place SPI flash read engine sitting directly behind the `iobank1` pad mapping. It converts single 32-bit word read requests from the instruction-fetch side into SPI mode-0 READ (0x03) frames on `xip_csn` / `xip_clk` / `xip_sdo`. It captures the flash's reply from `xip_sdi` and returns the assembled little-endian word. Only one transaction is in flight at a time.

## Interface

Parameters:
- `CLK_DIV`, default 2: SPI half-period in `clk` cycles; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `arstn`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  read request valid.
- `req_ready`  out  1  engine idle; a request is accepted on a `clk` edge where `req_valid && req_ready`.
- `req_addr`  in  24  flash byte address, latched on accept.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data` is valid.
- `rsp_data`  out  32  read word; holds its value until the next response.
- `xip_csn`  out  1  flash chip select, active-low.
- `xip_clk`  out  1  SPI clock; idles low (mode 0).
- `xip_sdo`  out  1  controller-to-flash serial data.
- `xip_sdi`  in  1  flash-to-controller serial data.

## Operation

- The FSM states are IDLE, SHIFT, RESP and GAP.
- `req_ready` is 1 exactly in IDLE. It is decoded from the state register with no combinational path from `req_valid`.
- **IDLE → SHIFT on accept:**
  - latch `{8'h03, req_addr}` into the 32-bit transmit shift register;
  - clear the 6-bit bit counter;
  - drive `xip_csn` low;
  - drive `xip_sdo` with the transmit MSB.
- **SHIFT:** 64 SPI bits, each a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
- **At the `clk` edge ending each high phase:**
  - `xip_clk` goes low;
  - `xip_sdi` is sampled into the receive shift register;
  - the transmit register shifts left, and `xip_sdo` takes the next bit (0 after bit 31);
  - the bit counter increments.
- Bits 0-31 are the command and address, MSB first. Bits 32-63 are data; `xip_sdi` is don't-care during bits 0-31.
- **Data assembly:** bytes arrive MSB-first within each byte. Byte k (k=0..3) maps to `rsp_data[8k+7:8k]`.
- **SHIFT → RESP** at the edge ending bit 63's high phase. On that edge `xip_csn` goes high and `xip_sdo` goes 0.
- **RESP:** lasts one cycle. `rsp_valid` = 1 and `rsp_data` is updated from the receive register. There is no backpressure.
- **GAP:** `xip_csn` is held high for `2*CLK_DIV` cycles (flash deselect time), then the FSM returns to IDLE.
- `req_addr` changes after accept have no effect on the current frame.

## Timing

- **Reset values (asynchronous, immediate, including mid-frame):**
  - state IDLE, `req_ready` 1;
  - `xip_csn` 1, `xip_clk` 0, `xip_sdo` 0;
  - `rsp_valid` 0, `rsp_data` 0;
  - all counters 0.
- After `arstn` rises, the first request starts a complete fresh frame.
- **Accept at edge T0:** `xip_csn` low from T0.
  - First `xip_clk` rise at T0 + `CLK_DIV`.
  - 64th rise at T0 + 127·`CLK_DIV`.
  - `xip_csn` high at T0 + 128·`CLK_DIV`.
  - `rsp_valid` high at T0 + 128·`CLK_DIV` + 1.
  - `req_ready` high at T0 + 130·`CLK_DIV` + 1.
- Exactly 64 `xip_clk` rising edges per frame. `xip_clk` is never high while `xip_csn` is high.
- All SPI outputs are driven directly from flops (glitch-free at the pads).

## Structure

- **Package `xip_pkg`:**
  - `XIP_CMD_READ = 8'h03`;
  - `XIP_FRAME_BITS = 64`;
  - FSM state enum `xip_state_t`.
- **Sub-module `xip_sclk_div`:** half-period counter producing `phase_end` and `phase_is_high` strobes. It is enabled in SHIFT and GAP and reset on accept. The top level holds the FSM and the shift registers.

## Test plan

- **Reset:** hold `arstn`=0 for 5 cycles → `xip_csn`=1, `xip_clk`=0, `xip_sdo`=0, `rsp_valid`=0, `rsp_data`=0, `req_ready`=1.
- **Single read, `CLK_DIV`=2, addr 0x000100, flash model returns EF BE AD DE:**
  - `xip_sdo` carries 0x03000100 MSB first;
  - 64 `xip_clk` rises;
  - `rsp_data`=0xDEADBEEF with `rsp_valid` pulsing at accept+257.
- **Back-to-back, `req_valid` held with addresses 0x000000 then 0x000004:**
  - second `xip_csn` fall is ≥5 cycles after the first `xip_csn` rise;
  - `req_ready`=0 throughout each frame;
  - two `rsp_valid` pulses.
- **`CLK_DIV`=1:** `xip_clk` period is 2 cycles; `rsp_valid` at accept+129; data correct.
- **Mid-frame reset:** assert `arstn`=0 during the address phase (bit 20) → `xip_csn`=1 and `xip_clk`=0 in the same cycle, no `rsp_valid`. The next request produces a full correct 64-bit frame.
- **Address latching:** toggle `req_addr` to 0xFFFFFF one cycle after accept → the serialized address still equals the accepted value.
